// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one external adder among NUM_REQ requesters
// Optional overflow counter output enabled by defining ADDER_ARB_OVF_CNT_EN.

module adder_arbiter #(
    parameter int  NUM_REQ       = 4,
    parameter int  WIDTH         = 32,
    parameter int  SETTLE_CYCLES = 2,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,

    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout,
    input  logic                     add_ovf,

`ifdef ADDER_ARB_OVF_CNT_EN
    output logic [15:0]              ovf_count,
`endif
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] pick_id;
    logic            pick_found;
    logic [3:0]      settle_cnt;
    logic [ID_W-1:0] rr_ptr_nxt;
    int              idx;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    assign rr_ptr_nxt = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign rsp_valid  = (state == RESP);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    req_ready[pick_id] = 1'b1;
                    state_nxt          = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt <= 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A grant during reset would look like a transfer to the requester.
        if (!rst_n) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            settle_cnt <= '0;
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id   <= pick_id;
                        add_a      <= req_a[int'(pick_id)*WIDTH +: WIDTH];
                        add_b      <= req_b[int'(pick_id)*WIDTH +: WIDTH];
                        add_cin    <= req_cin[pick_id];
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        settle_cnt <= '0;
                        rsp_id     <= grant_id;
                        rsp_sum    <= add_sum;
                        rsp_cout   <= add_cout;
                        rsp_ovf    <= add_ovf;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= rr_ptr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDER_ARB_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (state == RESP && rsp_ready && rsp_ovf && ovf_count != 16'hFFFF) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed vector bench for adder_arbiter with a behavioural adder

module tb_adder_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int S  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NR-1:0]   req_valid, req_ready, req_cin;
    logic [NR*W-1:0] req_a, req_b;
    logic [W-1:0]    add_a, add_b, add_sum;
    logic            add_cin, add_cout, add_ovf;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_sum;
    logic            rsp_cout, rsp_ovf;
`ifdef ADDER_ARB_OVF_CNT_EN
    logic [15:0]     ovf_count;
`endif

    adder_arbiter #(.NUM_REQ(NR), .WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf),
`ifdef ADDER_ARB_OVF_CNT_EN
        .ovf_count(ovf_count),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    always_comb begin
        {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
        add_ovf = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
    end

    typedef struct {
        int         id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[5];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_grant();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (|req_ready) return;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        logic [NR-1:0] exp_gnt;
        exp_gnt = '0;
        exp_gnt[v.id] = 1'b1;
        req_a[v.id*W +: W] = v.a;
        req_b[v.id*W +: W] = v.b;
        req_cin = '0;
        req_cin[v.id] = v.cin;
        req_valid = exp_gnt;
        rsp_ready = 1'b1;
        wait_grant();
        check("vec_grant", req_ready, exp_gnt);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("vec_grant_pulse", req_ready, 0);
        wait_rsp(n);
        check("vec_latency", n + 1, S + 1);
        check("vec_id", rsp_id, v.id);
        check("vec_sum", rsp_sum, v.sum);
        check("vec_cout", rsp_cout, v.cout);
        check("vec_ovf", rsp_ovf, v.ovf);
        @(negedge clk);
        check("vec_rsp_drop", rsp_valid, 0);
        check("vec_hold_a", add_a, v.a);
        check("vec_hold_cin", add_cin, v.cin);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n, got, rv;
        int rr_id[5];
        logic [31:0] rr_sum[4];

        vecs[0] = '{0, 32'd100,        32'hFFFFFFCE, 1'b0, 32'd50,        1'b1, 1'b0};
        vecs[1] = '{2, 32'h7FFFFFFF,   32'd1,        1'b0, 32'h80000000,  1'b0, 1'b1};
        vecs[2] = '{1, 32'h80000000,   32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF,  1'b1, 1'b1};
        vecs[3] = '{3, 32'd5,          32'd7,        1'b1, 32'd13,        1'b0, 1'b0};
        vecs[4] = '{1, 32'hFFFFFFFF,   32'd0,        1'b1, 32'd0,         1'b1, 1'b0};
        rr_id   = '{0, 1, 2, 3, 0};
        rr_sum  = '{32'd1001, 32'd2002, 32'd3003, 32'd4004};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = '1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_cout", rsp_cout, 0);
        check("rst_rsp_ovf", rsp_ovf, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_add_cin", add_cin, 0);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
`ifdef ADDER_ARB_OVF_CNT_EN
        check("ovf_count", ovf_count, 2);
`endif

        // Round robin with everyone continuously valid.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W] = 32'(1000 * (i + 1));
            req_b[i*W +: W] = 32'(i + 1);
        end
        req_cin = '0;
        rsp_ready = 1'b1;
        req_valid = '1;
        got = 0;
        for (int k = 0; k < 200 && got < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                check("rr_id", rsp_id, rr_id[got]);
                check("rr_sum", rsp_sum, rr_sum[rr_id[got]]);
                got++;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        check("rr_count", got, 5);

        // Reset during SETTLE abandons the op and returns rr_ptr to 0.
        req_a[2*W +: W] = 32'd7;
        req_b[2*W +: W] = 32'd8;
        req_valid = 4'b0100;
        wait_grant();
        check("mid_grant", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_add_a", add_a, 0);
        check("mid_add_b", add_b, 0);
        check("mid_rsp_sum", rsp_sum, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rv = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) rv++;
        end
        check("mid_no_rsp", rv, 0);
        @(posedge clk); #1;
        req_a[0 +: W] = 32'd40;
        req_b[0 +: W] = 32'd2;
        req_valid = 4'b1001;
        wait_grant();
        check("mid_ptr_zero", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        wait_rsp(n);
        check("mid_after_id", rsp_id, 0);
        check("mid_after_sum", rsp_sum, 42);
        @(posedge clk); #1;

        // Backpressure in RESP.
        do_reset();
        req_a[0 +: W] = 32'd10; req_b[0 +: W] = 32'd20;
        req_a[W +: W] = 32'd1;  req_b[W +: W] = 32'd2;
        req_cin = '0;
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        wait_grant();
        check("bp_grant", req_ready, 4'b0001);
        wait_rsp(n);
        check("bp_sum", rsp_sum, 30);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_held", rsp_valid, 1);
            check("bp_sum_held", rsp_sum, 30);
            check("bp_no_grant", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", rsp_valid, 1);
        @(negedge clk);
        check("bp_next_grant", req_ready, 4'b0010);
        check("bp_rsp_drop", rsp_valid, 0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        wait_rsp(n);
        check("bp_second_id", rsp_id, 1);
        check("bp_second_sum", rsp_sum, 3);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
